// File: rtl/wb_port_arbiter_pkg.sv
// wb_port_arbiter_pkg: shared write-back request type and arbiter defaults
package wb_port_arbiter_pkg;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_req_t;

   localparam int WB_STARVE_LIMIT_DEFAULT = 3;

endpackage

// File: rtl/wb_port_arbiter_fifo.sv
// wb_fifo: small synchronous FIFO of write-back requests (power-of-two depth)
module wb_fifo
   import wb_port_arbiter_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  wb_req_t                    din,
   input  logic                       pop,
   output wb_req_t                    dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   wb_req_t       mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          do_push, do_pop;

   assign full    = count == CW'(DEPTH);
   assign empty   = count == '0;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // storage is only written on push; contents after reset are don't-care
   always_ff @(posedge clk)
      if (do_push) mem[wr_ptr] <= din;

   // pointers wrap naturally at the power-of-two depth; count tracks occupancy
   always_ff @(posedge clk)
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end

endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between execute and load results (WB_ARB_FWD_EN adds forwarding outputs)
module wb_port_arbiter
   import wb_port_arbiter_pkg::*;
#(
   parameter int FIFO_DEPTH   = 2,
   parameter int STARVE_LIMIT = WB_STARVE_LIMIT_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ex_valid,
   input  logic [4:0]  ex_rd,
   input  logic [31:0] ex_data,
   output logic        ex_ready,
   input  logic        ld_valid,
   input  logic [4:0]  ld_rd,
   input  logic [31:0] ld_data,
   input  logic [31:0] ld_mask,
   output logic        ld_ready,
   output logic        rf_we,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata,
   output logic        ld_pending
`ifdef WB_ARB_FWD_EN
   ,
   output logic        fwd_valid,
   output logic [4:0]  fwd_rd,
   output logic [31:0] fwd_data
`endif
);

   localparam int CW = $clog2(FIFO_DEPTH+1);
   localparam int SW = $clog2(STARVE_LIMIT+1);
   localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

   wb_req_t       head, push_req, win_req;
   logic [CW-1:0] count;
   logic [SW-1:0] starve_cnt;
   logic          full, empty, push, ex_req, ld_cand, ex_win, ld_win, out_is_ld;

   assign push_req = wb_req_t'{rd: ld_rd, data: ld_data & ld_mask};
   assign push     = rst_n && ld_valid && !full && ld_rd != 5'd0;

   wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .din   (push_req),
      .pop   (ld_win),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   assign ex_req   = rst_n && ex_valid && ex_rd != 5'd0;
   assign ld_cand  = rst_n && !empty;
   assign ex_win   = ex_req && (!ld_cand || starve_cnt == LIMIT);
   assign ld_win   = ld_cand && !ex_win;
   assign win_req  = ex_win ? wb_req_t'{rd: ex_rd, data: ex_data} : head;
   assign ex_ready = rst_n && ex_valid && (ex_rd == 5'd0 || ex_win);
   assign ld_ready = count != CW'(FIFO_DEPTH);
   assign ld_pending = !empty || (rf_we && out_is_ld);

`ifdef WB_ARB_FWD_EN
   assign fwd_valid = ex_win || ld_win;
   assign fwd_rd    = win_req.rd;
   assign fwd_data  = win_req.data;
`endif

   // count cycles an execute request loses to the FIFO; a zero-rd execute leaves it alone
   always_ff @(posedge clk)
      if (!rst_n) starve_cnt <= '0;
      else if (!ex_valid || ex_win) starve_cnt <= '0;
      else if (ex_req && starve_cnt != LIMIT) starve_cnt <= starve_cnt + 1'b1;

   // register the winning write; address and data hold when nothing wins
   always_ff @(posedge clk)
      if (!rst_n) begin
         rf_we     <= 1'b0;
         rf_waddr  <= '0;
         rf_wdata  <= '0;
         out_is_ld <= 1'b0;
      end else begin
         rf_we     <= ex_win || ld_win;
         out_is_ld <= ld_win;
         if (ex_win || ld_win) begin
            rf_waddr <= win_req.rd;
            rf_wdata <= win_req.data;
         end
      end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: vector table, hand sequences and a randomized queue model for wb_port_arbiter
module tb_wb_port_arbiter;
   import wb_port_arbiter_pkg::*;

   localparam int FD = 2;
   localparam int SL = 3;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        ex_valid = 1'b0, ld_valid = 1'b0;
   logic [4:0]  ex_rd = '0, ld_rd = '0;
   logic [31:0] ex_data = '0, ld_data = '0, ld_mask = '0;
   logic        ex_ready, ld_ready, rf_we, ld_pending;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic        exv;
      logic [4:0]  exr;
      logic [31:0] exd;
      logic        ldv;
      logic [4:0]  ldr;
      logic [31:0] ldd;
      logic [31:0] ldm;
      logic        e_exr;
      logic        e_ldr;
      logic        we1;
      logic [4:0]  a1;
      logic [31:0] d1;
      logic        p1;
      logic        we2;
      logic [4:0]  a2;
      logic [31:0] d2;
   } vec_t;

   always #5 clk = ~clk;

   wb_port_arbiter #(.FIFO_DEPTH(FD), .STARVE_LIMIT(SL)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ex_valid   (ex_valid),
      .ex_rd      (ex_rd),
      .ex_data    (ex_data),
      .ex_ready   (ex_ready),
      .ld_valid   (ld_valid),
      .ld_rd      (ld_rd),
      .ld_data    (ld_data),
      .ld_mask    (ld_mask),
      .ld_ready   (ld_ready),
      .rf_we      (rf_we),
      .rf_waddr   (rf_waddr),
      .rf_wdata   (rf_wdata),
      .ld_pending (ld_pending)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic nxt;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      ex_valid = 1'b0;
      ex_rd    = '0;
      ld_valid = 1'b0;
      ld_rd    = '0;
   endtask

   task automatic do_reset;
      rst_n = 1'b0;
      idle();
      nxt();
      nxt();
      rst_n = 1'b1;
   endtask

   vec_t        vecs [6];
   wb_req_t     q [$];
   logic [4:0]  nrd, exp_ld;
   logic [SL:0] starve;
   logic        m_we, m_ld, exq, hq, exw, lw, acc, e_ldr;
   logic [4:0]  m_addr;
   logic [31:0] m_data;

   initial begin
      vecs[0] = '{1'b1, 5'd5,  32'h0000_1234, 1'b0, 5'd0,  32'h0,         32'h0,
                  1'b1, 1'b1, 1'b1, 5'd5,  32'h0000_1234, 1'b0, 1'b0, 5'd0,  32'h0};
      vecs[1] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd7,  32'hAABB_CCDD, 32'h0000_00FF,
                  1'b0, 1'b1, 1'b0, 5'd0,  32'h0,         1'b1, 1'b1, 5'd7,  32'h0000_00DD};
      vecs[2] = '{1'b1, 5'd0,  32'h5555_5555, 1'b1, 5'd0,  32'h6666_6666, 32'hFFFF_FFFF,
                  1'b1, 1'b1, 1'b0, 5'd0,  32'h0,         1'b0, 1'b0, 5'd0,  32'h0};
      vecs[3] = '{1'b1, 5'd3,  32'hCAFE_F00D, 1'b1, 5'd4,  32'h1234_5678, 32'hFFFF_0000,
                  1'b1, 1'b1, 1'b1, 5'd3,  32'hCAFE_F00D, 1'b1, 1'b1, 5'd4,  32'h1234_0000};
      vecs[4] = '{1'b1, 5'd0,  32'hDEAD_BEEF, 1'b1, 5'd10, 32'h8765_4321, 32'h0000_FFFF,
                  1'b1, 1'b1, 1'b0, 5'd0,  32'h0,         1'b1, 1'b1, 5'd10, 32'h0000_4321};
      vecs[5] = '{1'b1, 5'd31, 32'hFFFF_FFFF, 1'b0, 5'd0,  32'h0,         32'h0,
                  1'b1, 1'b1, 1'b1, 5'd31, 32'hFFFF_FFFF, 1'b0, 1'b0, 5'd0,  32'h0};

      do_reset();
      chk("reset_rf_we", 32'(rf_we), 32'd0);
      chk("reset_rf_waddr", 32'(rf_waddr), 32'd0);
      chk("reset_rf_wdata", rf_wdata, 32'd0);
      chk("reset_ld_ready", 32'(ld_ready), 32'd1);
      chk("reset_ld_pending", 32'(ld_pending), 32'd0);

      for (int i = 0; i < 6; i++) begin
         do_reset();
         ex_valid = vecs[i].exv; ex_rd = vecs[i].exr; ex_data = vecs[i].exd;
         ld_valid = vecs[i].ldv; ld_rd = vecs[i].ldr; ld_data = vecs[i].ldd; ld_mask = vecs[i].ldm;
         #1;
         chk("vec_ex_ready", 32'(ex_ready), 32'(vecs[i].e_exr));
         chk("vec_ld_ready", 32'(ld_ready), 32'(vecs[i].e_ldr));
         nxt();
         idle();
         chk("vec_we1", 32'(rf_we), 32'(vecs[i].we1));
         chk("vec_pending1", 32'(ld_pending), 32'(vecs[i].p1));
         if (vecs[i].we1) begin
            chk("vec_waddr1", 32'(rf_waddr), 32'(vecs[i].a1));
            chk("vec_wdata1", rf_wdata, vecs[i].d1);
         end
         nxt();
         chk("vec_we2", 32'(rf_we), 32'(vecs[i].we2));
         if (vecs[i].we2) begin
            chk("vec_waddr2", 32'(rf_waddr), 32'(vecs[i].a2));
            chk("vec_wdata2", rf_wdata, vecs[i].d2);
         end
      end

      // continuous loads against a continuous rd=9 execute, then reset with a full FIFO
      do_reset();
      nrd = 5'd1;
      exp_ld = 5'd1;
      for (int c = 0; c <= 9; c++) begin
         rst_n = (c != 9);
         ex_valid = (c >= 1); ex_rd = 5'd9; ex_data = 32'h0000_0909;
         ld_valid = 1'b1; ld_rd = nrd; ld_data = {4{3'b000, nrd}}; ld_mask = '1;
         #1;
         if (c >= 1 && c <= 8) chk("starve_ex_ready", 32'(ex_ready), 32'(c == 4 || c == 8));
         chk("starve_ld_ready", 32'(ld_ready), 32'(!(c == 5 || c == 9)));
         if (ld_valid && ld_ready && rst_n) nrd = nrd + 5'd1;
         nxt();
         if (rf_we) begin
            if (rf_waddr == 5'd9) chk("starve_ex_data", rf_wdata, 32'h0000_0909);
            else begin
               chk("load_order", 32'(rf_waddr), 32'(exp_ld));
               chk("load_data", rf_wdata, {4{3'b000, exp_ld}});
               exp_ld = exp_ld + 5'd1;
            end
         end
      end
      chk("starve_load_count", 32'(exp_ld), 32'd7);
      idle();
      rst_n = 1'b1;
      #1;
      chk("post_reset_rf_we", 32'(rf_we), 32'd0);
      chk("post_reset_ld_ready", 32'(ld_ready), 32'd1);
      chk("post_reset_ld_pending", 32'(ld_pending), 32'd0);
      for (int c = 0; c < 3; c++) begin
         nxt();
         chk("no_stale_write", 32'(rf_we), 32'd0);
      end

      // randomized traffic against a queue-based model of the port
      do_reset();
      q.delete();
      starve = '0; m_we = 1'b0; m_ld = 1'b0; m_addr = '0; m_data = '0;
      for (int c = 0; c < 600; c++) begin
         rst_n    = ($urandom_range(0, 59) != 0);
         ex_valid = ($urandom_range(0, 2) != 0);
         ex_rd    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         ex_data  = $urandom;
         ld_valid = ($urandom_range(0, 1) != 0);
         ld_rd    = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         ld_data  = $urandom;
         ld_mask  = $urandom;
         #1;
         e_ldr = q.size() < FD;
         chk("rand_ld_ready", 32'(ld_ready), 32'(e_ldr));
         if (!rst_n) begin
            q.delete();
            starve = '0; m_we = 1'b0; m_ld = 1'b0; m_addr = '0; m_data = '0;
         end else begin
            exq = ex_valid && ex_rd != 5'd0;
            hq  = q.size() > 0;
            exw = exq && (!hq || starve == SL);
            lw  = hq && !exw;
            acc = ld_valid && e_ldr && ld_rd != 5'd0;
            chk("rand_ex_ready", 32'(ex_ready), 32'(ex_valid && (ex_rd == 5'd0 || exw)));
            m_we = exw || lw;
            m_ld = lw;
            if (exw) begin
               m_addr = ex_rd;
               m_data = ex_data;
            end else if (lw) begin
               m_addr = q[0].rd;
               m_data = q[0].data;
               void'(q.pop_front());
            end
            if (!ex_valid || exw) starve = '0;
            else if (exq && starve < SL) starve = starve + 1'b1;
            if (acc) q.push_back(wb_req_t'{rd: ld_rd, data: ld_data & ld_mask});
         end
         nxt();
         chk("rand_rf_we", 32'(rf_we), 32'(m_we));
         chk("rand_rf_waddr", 32'(rf_waddr), 32'(m_addr));
         chk("rand_rf_wdata", rf_wdata, m_data);
         chk("rand_ld_pending", 32'(ld_pending), 32'(q.size() > 0 || m_ld));
      end

      idle();
      rst_n = 1'b1;
      nxt();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
